speed_loop: RTL and testbench

SPEED_LOOP -- requirements
Module: speed_loop

---
 rtl/speed_loop_pkg.sv | 46 ++++
 rtl/speed_pi_mult.sv | 20 ++
 rtl/speed_loop.sv | 188 ++++++++++++++++++
 tb/tb_speed_loop.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/speed_loop_pkg.sv
// Shared definitions for the speed loop: widths, FSM encoding and saturation helpers.
package speed_loop_pkg;

    localparam int unsigned POS_W     = 16;
    localparam int unsigned ERR_W     = 16;
    localparam int unsigned IQ_W      = 12;
    localparam int unsigned GAIN_FRAC = 8;
    localparam int unsigned GAIN_W    = 16;
    // Signed error times unsigned gain needs one extra bit for the sign.
    localparam int unsigned PROD_W    = ERR_W + GAIN_W + 1;
    localparam int unsigned MULT_W    = PROD_W - GAIN_FRAC;
    // Headroom so p + integ and integ + di never overflow before clamping.
    localparam int unsigned ACC_W     = MULT_W + 2;

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StError,
        StMulP,
        StMulI,
        StSum,
        StDone
    } sl_state_e;

    // Symmetric clamp to +/-lim.
    function automatic logic signed [ACC_W-1:0] saturate(
        input logic signed [ACC_W-1:0] val,
        input logic signed [ACC_W-1:0] lim
    );
        if (val > lim) begin
            return lim;
        end else if (val < -lim) begin
            return -lim;
        end
        return val;
    endfunction

    // Clamp a 17-bit difference into the full 16-bit signed range.
    function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [ERR_W:0] val);
        if (val[ERR_W] != val[ERR_W-1]) begin
            return val[ERR_W] ? {1'b1, {(ERR_W-1){1'b0}}} : {1'b0, {(ERR_W-1){1'b1}}};
        end
        return val[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/speed_pi_mult.sv
// Combinational signed-error by unsigned-gain multiply, scaled down by the gain's fraction bits.
module speed_pi_mult
    import speed_loop_pkg::*;
(
    input  logic signed [ERR_W-1:0]  err_i,
    input  logic        [GAIN_W-1:0] gain_i,
    output logic signed [MULT_W-1:0] prod_o
);

    logic signed [PROD_W-1:0] err_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod_full;

    assign err_ext   = PROD_W'(err_i);
    assign gain_ext  = $signed(PROD_W'(gain_i));
    assign prod_full = err_ext * gain_ext;
    // Arithmetic shift floors toward -inf; the upper bits are pure sign extension.
    assign prod_o    = MULT_W'(prod_full >>> GAIN_FRAC);

endmodule

// File: rtl/speed_loop.sv
// Speed loop: samples the encoder on a fixed period, derives speed and runs a
// saturating PI controller with anti-windup that produces the q-current target.
module speed_loop
    import speed_loop_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 5000,
    parameter int unsigned IQ_LIMIT      = 2047,
    parameter int unsigned INT_LIMIT     = 2047
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic                    iSL_en,
    input  logic [POS_W-1:0]        iPosition,
    input  logic signed [ERR_W-1:0] iSpeed_set,
    input  logic [GAIN_W-1:0]       iKp,
    input  logic [GAIN_W-1:0]       iKi,
    output logic signed [POS_W-1:0] oSpeed,
    output logic signed [IQ_W-1:0]  oIq_set,
    output logic                    oCal_done
);

    localparam int unsigned TmrW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [TmrW-1:0] TmrLast = TmrW'(PERIOD_CYCLES - 1);
    localparam logic signed [ACC_W-1:0] IqLim  = ACC_W'(IQ_LIMIT);
    localparam logic signed [ACC_W-1:0] IntLim = ACC_W'(INT_LIMIT);

    sl_state_e state_q, state_d;

    logic [TmrW-1:0]          timer_q, timer_d;
    logic                     tick;

    logic [POS_W-1:0]         pos_prev_q;
    logic                     prime_q;
    logic signed [POS_W-1:0]  speed_q;
    logic signed [ERR_W-1:0]  err_q;
    logic signed [MULT_W-1:0] p_q;
    logic signed [ACC_W-1:0]  integ_q;
    logic                     sat_hi_q;
    logic                     sat_lo_q;
    logic signed [POS_W-1:0]  speed_out_q;
    logic signed [IQ_W-1:0]   iq_q;

    logic                     cap_en;
    logic                     err_en;
    logic                     mulp_en;
    logic                     muli_en;
    logic                     sum_en;
    logic                     done;
    logic [GAIN_W-1:0]        mult_gain;
    logic signed [MULT_W-1:0] mult_prod;

    logic signed [ERR_W:0]    err_wide;
    logic signed [ACC_W-1:0]  integ_new;
    logic signed [ACC_W-1:0]  u_raw;
    logic                     freeze;

    // Sample timer next state: count while enabled, park at zero when disabled.
    assign tick = iSL_en && (timer_q == TmrLast);

    always_comb begin
        timer_d = timer_q + TmrW'(1);
        if (!iSL_en || tick) begin
            timer_d = '0;
        end
    end

    // Timer register.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // FSM state register.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one pass per tick, abandoned immediately when disabled.
    always_comb begin
        state_d = state_q;
        if (!iSL_en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    if (tick) state_d = StCapture;
                StCapture: state_d = prime_q ? StError : StIdle;
                StError:   state_d = StMulP;
                StMulP:    state_d = StMulI;
                StMulI:    state_d = StSum;
                StSum:     state_d = StDone;
                StDone:    state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    // FSM outputs: per-state datapath strobes and multiplier gain select.
    always_comb begin
        cap_en    = 1'b0;
        err_en    = 1'b0;
        mulp_en   = 1'b0;
        muli_en   = 1'b0;
        sum_en    = 1'b0;
        done      = 1'b0;
        mult_gain = iKp;
        unique case (state_q)
            StIdle:    ;
            StCapture: cap_en  = iSL_en;
            StError:   err_en  = iSL_en;
            StMulP:    mulp_en = iSL_en;
            StMulI: begin
                muli_en   = iSL_en;
                mult_gain = iKi;
            end
            StSum:     sum_en  = iSL_en;
            StDone:    done    = 1'b1;
            default:   ;
        endcase
    end

    speed_pi_mult u_mult (
        .err_i  (err_q),
        .gain_i (mult_gain),
        .prod_o (mult_prod)
    );

    assign err_wide  = (ERR_W+1)'(iSpeed_set) - (ERR_W+1)'(speed_q);
    // Hold the integrator while the last output was clipped and the error pushes further out.
    assign freeze    = (sat_hi_q && !err_q[ERR_W-1] && (err_q != '0)) ||
                       (sat_lo_q && err_q[ERR_W-1]);
    assign integ_new = saturate(integ_q + ACC_W'(mult_prod), IntLim);
    assign u_raw     = ACC_W'(p_q) + integ_q;

    // Datapath registers; disabling the loop clears controller state but keeps oSpeed.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pos_prev_q  <= '0;
            prime_q     <= 1'b0;
            speed_q     <= '0;
            err_q       <= '0;
            p_q         <= '0;
            integ_q     <= '0;
            sat_hi_q    <= 1'b0;
            sat_lo_q    <= 1'b0;
            speed_out_q <= '0;
            iq_q        <= '0;
        end else if (!iSL_en) begin
            prime_q  <= 1'b0;
            integ_q  <= '0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
            iq_q     <= '0;
        end else begin
            if (cap_en) begin
                speed_q    <= iPosition - pos_prev_q;
                pos_prev_q <= iPosition;
                prime_q    <= 1'b1;
            end
            if (err_en) begin
                err_q <= sat_err(err_wide);
            end
            if (mulp_en) begin
                p_q <= mult_prod;
            end
            if (muli_en && !freeze) begin
                integ_q <= integ_new;
            end
            if (sum_en) begin
                iq_q        <= IQ_W'(saturate(u_raw, IqLim));
                speed_out_q <= speed_q;
                sat_hi_q    <= (u_raw > IqLim);
                sat_lo_q    <= (u_raw < -IqLim);
            end
        end
    end

    assign oSpeed    = speed_out_q;
    assign oIq_set   = iq_q;
    assign oCal_done = done;

endmodule

// File: tb/tb_speed_loop.sv
// Self-checking bench for speed_loop: per-cycle comparison against a per-sample
// arithmetic model, plus directed scenarios with hand-computed expectations.
module tb_speed_loop;

    localparam int unsigned P = 16;
    localparam int IqLim  = 2047;
    localparam int IntLim = 2047;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iSL_en;
    logic [15:0] iPosition;
    logic [15:0] iSpeed_set;
    logic [15:0] iKp;
    logic [15:0] iKi;
    logic [15:0] oSpeed;
    logic [11:0] oIq_set;
    logic        oCal_done;

    int checks = 0;
    int errors = 0;

    always #5 iClk = ~iClk;

    speed_loop #(
        .PERIOD_CYCLES (P),
        .IQ_LIMIT      (IqLim),
        .INT_LIMIT     (IntLim)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iSL_en     (iSL_en),
        .iPosition  (iPosition),
        .iSpeed_set (iSpeed_set),
        .iKp        (iKp),
        .iKi        (iKi),
        .oSpeed     (oSpeed),
        .oIq_set    (oIq_set),
        .oCal_done  (oCal_done)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int iq_now();
        return int'($signed(oIq_set));
    endfunction

    function automatic int spd_now();
        return int'($signed(oSpeed));
    endfunction

    // Behavioural model: every enabled cycle advances a sample counter; on each
    // sample boundary the PI result is computed at once and published 6 cycles later.
    initial begin : model
        int          cnt, cyc, due, integ, spd, err, p, di, u;
        int          p_iq, p_spd, e_iq, e_spd;
        bit          primed, sat_hi, sat_lo, pend, e_done;
        logic [15:0] prev16, diff;
        longint      prod;
        cnt = 0; cyc = 0; due = 0; integ = 0; p_iq = 0; p_spd = 0; e_iq = 0; e_spd = 0;
        primed = 0; sat_hi = 0; sat_lo = 0; pend = 0; prev16 = '0;
        forever begin
            @(negedge iClk);
            cyc++;
            if (!iRst_n) begin
                cnt = 0; integ = 0; primed = 0; sat_hi = 0; sat_lo = 0; pend = 0;
                prev16 = '0; e_iq = 0; e_spd = 0;
                check("rst_iq", iq_now(), 0);
                check("rst_spd", spd_now(), 0);
                check("rst_done", int'(oCal_done), 0);
            end else begin
                e_done = pend && (due == cyc);
                if (e_done) begin
                    e_iq  = p_iq;
                    e_spd = p_spd;
                    pend  = 0;
                end
                check("cyc_done", int'(oCal_done), int'(e_done));
                check("cyc_iq", iq_now(), e_iq);
                check("cyc_spd", spd_now(), e_spd);
                if (!iSL_en) begin
                    cnt = 0; integ = 0; primed = 0; sat_hi = 0; sat_lo = 0; pend = 0; e_iq = 0;
                end else if (cnt == P - 1) begin
                    cnt = 0;
                    if (!primed) begin
                        prev16 = iPosition;
                        primed = 1;
                    end else begin
                        diff   = iPosition - prev16;
                        spd    = int'($signed(diff));
                        prev16 = iPosition;
                        err    = clampi(int'($signed(iSpeed_set)) - spd, -32768, 32767);
                        prod   = longint'(iKp) * longint'(err);
                        p      = int'(prod >>> 8);
                        prod   = longint'(iKi) * longint'(err);
                        di     = int'(prod >>> 8);
                        if (!((sat_hi && err > 0) || (sat_lo && err < 0)))
                            integ = clampi(integ + di, -IntLim, IntLim);
                        u      = p + integ;
                        sat_hi = (u > IqLim);
                        sat_lo = (u < -IqLim);
                        pend   = 1;
                        due    = cyc + 6;
                        p_iq   = clampi(u, -IqLim, IqLim);
                        p_spd  = spd;
                    end
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Wait for the next done pulse; returns outputs at that cycle and cycles waited.
    task automatic wait_done(input string name, output int iq, output int spd, output int waited);
        waited = 0;
        iq     = 0;
        spd    = 0;
        forever begin
            @(negedge iClk);
            waited++;
            if (oCal_done) begin
                iq  = iq_now();
                spd = spd_now();
                return;
            end
            if (waited > 3 * P + 10) begin
                checks++;
                errors++;
                $display("FAIL %s: no oCal_done within %0d cycles", name, waited);
                return;
            end
        end
    endtask

    initial begin : stim
        int iq, spd, w, n;
        iRst_n = 1'b0; iSL_en = 1'b0; iPosition = 16'd1000; iSpeed_set = 16'd100;
        iKp = 16'd256; iKi = 16'd0;
        repeat (3) @(posedge iClk);
        #1 iRst_n = 1'b1;
        @(negedge iClk);
        check("post_rst_iq", iq_now(), 0);
        check("post_rst_done", int'(oCal_done), 0);

        // Proportional only: priming sample first, then iq = err = 100.
        @(posedge iClk); #1 iSL_en = 1'b1;
        wait_done("p_only", iq, spd, w);
        check("p_only_iq", iq, 100);
        check("p_only_spd", spd, 0);
        check("p_only_latency", w, 2 * P + 6);

        // Reset mid-sample clears outputs; no done while disabled afterwards.
        repeat (5) @(posedge iClk);
        #1 iRst_n = 1'b0; iSL_en = 1'b0;
        @(negedge iClk);
        check("mid_rst_iq", iq_now(), 0);
        check("mid_rst_done", int'(oCal_done), 0);
        @(posedge iClk); #1 iRst_n = 1'b1;
        n = 0;
        repeat (P + 8) begin
            @(negedge iClk);
            if (oCal_done) n++;
        end
        check("no_done_after_rst", n, 0);

        // Encoder wrap in both directions.
        iSpeed_set = 16'd0; iPosition = 16'd65530;
        @(posedge iClk); #1 iSL_en = 1'b1;
        repeat (P + 2) @(posedge iClk);
        #1 iPosition = 16'd4;
        wait_done("wrap_fwd", iq, spd, w);
        check("wrap_fwd_spd", spd, 10);
        check("wrap_fwd_iq", iq, -10);
        @(posedge iClk); #1 iPosition = 16'd65530;
        wait_done("wrap_rev", iq, spd, w);
        check("wrap_rev_spd", spd, -10);
        check("wrap_rev_iq", iq, 10);

        // Integrator ramp: +10 per sample up to the integrator limit.
        @(posedge iClk); #1 iSL_en = 1'b0; iKp = 16'd0; iKi = 16'd64;
        iSpeed_set = 16'd40; iPosition = 16'd777;
        @(posedge iClk); #1 iSL_en = 1'b1;
        for (int k = 1; k <= 210; k++) begin
            wait_done("integ", iq, spd, w);
            check("integ_iq", iq, (10 * k > 2047) ? 2047 : 10 * k);
        end

        // Anti-windup: integrator must hold at 1250 while the output is clipped.
        @(posedge iClk); #1 iSL_en = 1'b0; iKp = 16'd256; iKi = 16'd64; iSpeed_set = 16'd5000;
        @(posedge iClk); #1 iSL_en = 1'b1;
        wait_done("aw_1", iq, spd, w);
        check("aw_sat1_iq", iq, 2047);
        wait_done("aw_2", iq, spd, w);
        check("aw_sat2_iq", iq, 2047);
        @(posedge iClk); #1 iSpeed_set = 16'd0;
        wait_done("aw_3", iq, spd, w);
        check("aw_release_iq", iq, 1250);
        @(posedge iClk); #1 iSpeed_set = -16'sd100;
        wait_done("aw_4", iq, spd, w);
        check("aw_neg_iq", iq, 1125);

        // Equal gains drive the integrator to its limit, then unwind.
        @(posedge iClk); #1 iKi = 16'd256; iSpeed_set = 16'd5000;
        wait_done("sat_1", iq, spd, w);
        check("sat_hi_iq", iq, 2047);
        @(posedge iClk); #1 iSpeed_set = 16'd0;
        wait_done("sat_2", iq, spd, w);
        check("sat_zero_iq", iq, 2047);
        @(posedge iClk); #1 iSpeed_set = -16'sd100;
        wait_done("sat_3", iq, spd, w);
        check("sat_leave_iq", iq, 1847);

        // Abort during MUL_P of the next sample, then re-prime.
        repeat (P - 3) @(posedge iClk);
        #1 iSL_en = 1'b0;
        @(negedge iClk);
        @(posedge iClk); #1 iSL_en = 1'b1;
        @(negedge iClk);
        check("abort_iq", iq_now(), 0);
        check("abort_done", int'(oCal_done), 0);
        wait_done("abort_reprime", iq, spd, w);
        check("abort_latency", w, 2 * P + 5);
        check("abort_iq_after", iq, -200);

        repeat (4) @(posedge iClk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
